// File: rtl/plugboard_config.sv
// plugboard_config
//   Setup-time programming front-end for the Enigma plugboard. Pairs successive
//   one-hot keyboard letters into swap entries, holds the symmetric 26-entry
//   substitution table and answers registered one-hot lookups through it.
//
// Ports
//   CLK           system clock, rising edge
//   RESET         asynchronous active-high reset
//   LETTER        one-hot letter to program (bit 0 = A)
//   LETTER_VALID  qualifies LETTER
//   CLEAR         synchronous clear of all pairs (priority over everything but RESET)
//   LOOKUP_IN     one-hot letter to translate
//   LOOKUP_OUT    registered translation, 0 for a non-one-hot LOOKUP_IN
//   PAIR_COUNT    committed pairs
//   AWAIT_SECOND  high while a first letter is held
//   DONE          one-cycle pulse after a commit
//   ERROR         one-cycle pulse after a rejected letter
module plugboard_config #(
  parameter int MAX_PAIRS = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [25:0] LETTER,
  input  logic        LETTER_VALID,
  input  logic        CLEAR,
  input  logic [25:0] LOOKUP_IN,
  output logic [25:0] LOOKUP_OUT,
  output logic [3:0]  PAIR_COUNT,
  output logic        AWAIT_SECOND,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_COMMIT} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_PAIRS);

  function automatic logic onehot_ok(input logic [25:0] x);
    return (x != 26'd0) && ((x & (x - 26'd1)) == 26'd0);
  endfunction

  function automatic logic [4:0] onehot_idx(input logic [25:0] x);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 26; i++)
      if (x[i]) idx = 5'(i);
    return idx;
  endfunction

  state_t             state_q, state_d;
  logic [25:0][25:0]  map_q, map_d;
  logic [4:0]         first_idx_q, first_idx_d;
  logic [4:0]         second_idx_q, second_idx_d;
  logic [3:0]         pair_count_q, pair_count_d;
  logic               await_q, await_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [25:0]        lookup_q, lookup_d;

  // Letter decode
  logic       letter_ok, letter_plugged, full;
  logic [4:0] letter_idx;
  logic       lookup_ok;
  logic [4:0] lookup_idx;

  assign letter_ok      = onehot_ok(LETTER);
  assign letter_idx     = onehot_idx(LETTER);
  assign letter_plugged = map_q[letter_idx] != (26'd1 << letter_idx);
  assign full           = pair_count_q >= MAX_CNT;
  assign lookup_ok      = onehot_ok(LOOKUP_IN);
  assign lookup_idx     = onehot_idx(LOOKUP_IN);

  // FSM decisions
  logic take_first, take_second, reject, commit;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    take_first  = 1'b0;
    take_second = 1'b0;
    reject      = 1'b0;
    commit      = 1'b0;
    case (state_q)
      S_IDLE:
        if (LETTER_VALID) begin
          if (!letter_ok || letter_plugged || full) reject = 1'b1;
          else begin
            take_first = 1'b1;
            state_d    = S_HELD;
          end
        end
      S_HELD:
        if (LETTER_VALID) begin
          if (!letter_ok || letter_plugged) reject = 1'b1;
          else if (letter_idx == first_idx_q) state_d = S_IDLE;  // cancel
          else begin
            take_second = 1'b1;
            state_d     = S_COMMIT;
          end
        end
      S_COMMIT: begin
        // LETTER_VALID deliberately ignored here
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // CLEAR wins: drops held/in-flight pairs and suppresses pulses
    if (CLEAR) begin
      state_d     = S_IDLE;
      take_first  = 1'b0;
      take_second = 1'b0;
      reject      = 1'b0;
      commit      = 1'b0;
    end
  end

  // Datapath / outputs
  always_comb begin
    map_d        = map_q;
    first_idx_d  = first_idx_q;
    second_idx_d = second_idx_q;
    pair_count_d = pair_count_q;
    done_d       = commit;
    error_d      = reject;
    await_d      = (state_d == S_HELD);
    if (take_first)  first_idx_d  = letter_idx;
    if (take_second) second_idx_d = letter_idx;
    // Both halves written together to keep the table symmetric
    if (commit) begin
      map_d[first_idx_q]  = 26'd1 << second_idx_q;
      map_d[second_idx_q] = 26'd1 << first_idx_q;
      if (pair_count_q < MAX_CNT) pair_count_d = pair_count_q + 4'd1;
    end
    if (CLEAR) begin
      for (int i = 0; i < 26; i++) map_d[i] = 26'd1 << i;
      pair_count_d = 4'd0;
    end
    // Reads the pre-edge table, so commit/clear edges return the old mapping
    lookup_d = lookup_ok ? map_q[lookup_idx] : 26'd0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 26; i++) map_q[i] <= 26'd1 << i;
      first_idx_q  <= 5'd0;
      second_idx_q <= 5'd0;
      pair_count_q <= 4'd0;
      await_q      <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      lookup_q     <= 26'd0;
    end else begin
      map_q        <= map_d;
      first_idx_q  <= first_idx_d;
      second_idx_q <= second_idx_d;
      pair_count_q <= pair_count_d;
      await_q      <= await_d;
      done_q       <= done_d;
      error_q      <= error_d;
      lookup_q     <= lookup_d;
    end
  end

  assign LOOKUP_OUT   = lookup_q;
  assign PAIR_COUNT   = pair_count_q;
  assign AWAIT_SECOND = await_q;
  assign DONE         = done_q;
  assign ERROR        = error_q;

endmodule

// File: tb/tb_plugboard_config.sv
module tb_plugboard_config;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [25:0] LETTER = 26'd0;
  logic        LETTER_VALID = 1'b0;
  logic        CLEAR = 1'b0;
  logic [25:0] LOOKUP_IN = 26'd0;
  logic [25:0] LOOKUP_OUT;
  logic [3:0]  PAIR_COUNT;
  logic        AWAIT_SECOND, DONE, ERROR;

  plugboard_config #(.MAX_PAIRS(10)) dut (
    .CLK(CLK), .RESET(RESET), .LETTER(LETTER), .LETTER_VALID(LETTER_VALID),
    .CLEAR(CLEAR), .LOOKUP_IN(LOOKUP_IN), .LOOKUP_OUT(LOOKUP_OUT),
    .PAIR_COUNT(PAIR_COUNT), .AWAIT_SECOND(AWAIT_SECOND), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [25:0] sb[$];     // expected LOOKUP_OUT, one per driven lookup
  int tmap[26];           // reference table: letter -> partner index

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge. A pending lookup
  // expectation is retired against the register that edge loaded.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (sb.size() != 0) chk("lookup", LOOKUP_OUT, sb.pop_front());
  endtask

  task automatic look(input logic [25:0] in, input logic [25:0] exp);
    LOOKUP_IN = in;
    sb.push_back(exp);
  endtask

  task automatic prog(input int idx);
    LETTER = 26'd1 << idx;
    LETTER_VALID = 1'b1;
    tick();
    LETTER_VALID = 1'b0;
  endtask

  task automatic pair(input int a, input int b);
    prog(a);
    chk("await_after_first", AWAIT_SECOND, 1);
    prog(b);
    chk("await_in_commit", AWAIT_SECOND, 0);
    tick();
    chk("done_after_commit", DONE, 1);
    tmap[a] = b;
    tmap[b] = a;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 26; i++) begin
      look(26'd1 << i, 26'd1 << tmap[i]);
      tick();
    end
    $display("sweep %s done", tag);
  endtask

  initial begin
    for (int i = 0; i < 26; i++) tmap[i] = i;
    repeat (2) tick();
    chk("rst_lookup", LOOKUP_OUT, 0);
    chk("rst_count", PAIR_COUNT, 0);
    chk("rst_await", AWAIT_SECOND, 0);
    chk("rst_done", DONE, 0);
    chk("rst_error", ERROR, 0);
    RESET = 1'b0;

    // Identity lookup
    look(26'd1, 26'd1);
    tick();
    chk("count0", PAIR_COUNT, 0);

    // Program A-Q with lookups straddling the commit edge
    prog(0);
    chk("await_held", AWAIT_SECOND, 1);
    prog(16);
    chk("await_commit", AWAIT_SECOND, 0);
    chk("done_early", DONE, 0);
    look(26'd1, 26'd1);                  // sampled on commit edge: old mapping
    tick();
    chk("done_pulse", DONE, 1);
    chk("count1", PAIR_COUNT, 1);
    tmap[0] = 16; tmap[16] = 0;
    look(26'd1, 26'd65536);              // sampled at k+1: new mapping
    tick();
    chk("done_gone", DONE, 0);
    look(26'd65536, 26'd1);
    tick();
    look(26'd2, 26'd2);
    tick();

    // Multi-hot in IDLE
    LETTER = 26'd3; LETTER_VALID = 1'b1;
    tick();
    LETTER_VALID = 1'b0;
    chk("err_multihot", ERROR, 1);
    chk("multihot_idle", AWAIT_SECOND, 0);
    tick();
    chk("err_one_cycle", ERROR, 0);

    // Already-plugged A, back-to-back with an invalid zero letter
    prog(0);
    chk("err_plugged", ERROR, 1);
    LETTER = 26'd0; LETTER_VALID = 1'b1;
    tick();
    LETTER_VALID = 1'b0;
    chk("err_b2b", ERROR, 1);

    // Hold B, invalid in HELD, then cancel with B
    prog(1);
    chk("held_b", AWAIT_SECOND, 1);
    chk("held_b_noerr", ERROR, 0);
    LETTER = 26'd0; LETTER_VALID = 1'b1;
    tick();
    LETTER_VALID = 1'b0;
    chk("err_in_held", ERROR, 1);
    chk("still_held", AWAIT_SECOND, 1);
    prog(1);
    chk("cancel_await", AWAIT_SECOND, 0);
    chk("cancel_noerr", ERROR, 0);
    chk("cancel_nodone", DONE, 0);
    tick();
    chk("cancel_nodone2", DONE, 0);
    chk("cancel_count", PAIR_COUNT, 1);

    // Fill to capacity, back-to-back (next first letter while DONE is high)
    pair(1, 2);  pair(3, 4);  pair(5, 6);  pair(7, 8);  pair(9, 10);
    pair(11, 12); pair(13, 14); pair(15, 17); pair(18, 19);
    chk("count10", PAIR_COUNT, 10);
    prog(20);
    chk("err_full", ERROR, 1);
    chk("full_not_held", AWAIT_SECOND, 0);
    chk("count_sat", PAIR_COUNT, 10);
    sweep("full");

    // CLEAR with a same-cycle rejectable letter and a lookup on the clear edge
    CLEAR = 1'b1; LETTER = 26'd1 << 20; LETTER_VALID = 1'b1;
    look(26'd1, 26'd65536);
    tick();
    CLEAR = 1'b0; LETTER_VALID = 1'b0;
    chk("clr_noerr", ERROR, 0);
    chk("clr_count", PAIR_COUNT, 0);
    for (int i = 0; i < 26; i++) tmap[i] = i;

    // CLEAR during COMMIT discards the pair
    prog(20);
    prog(21);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    chk("clr_commit_nodone", DONE, 0);
    chk("clr_commit_count", PAIR_COUNT, 0);
    tick();
    chk("clr_commit_nodone2", DONE, 0);
    sweep("cleared");

    // Async reset while HELD, with a committed pair present
    pair(5, 6);
    prog(7);
    chk("held_pre_rst", AWAIT_SECOND, 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_await", AWAIT_SECOND, 0);
    chk("async_count", PAIR_COUNT, 0);
    #1 RESET = 1'b0;
    tmap[5] = 5; tmap[6] = 6;
    look(26'd0, 26'd0);
    tick();
    look(26'd1 << 5, 26'd1 << 5);
    tick();
    chk("post_rst_await", AWAIT_SECOND, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
